// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci job scheduler: default data width, FSM state
// encoding and the result record carried on the output stream.
package fib_pkg;

   localparam int unsigned FIB_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUT
   } sched_state_e;

   typedef struct packed {
      logic [FIB_DATA_W-1:0] n;
      logic [FIB_DATA_W-1:0] f;
      logic                  err;
   } fib_result_t;

endpackage

// File: rtl/fib_job_scheduler_if.sv
// Request stream, core start/done link and result stream of the scheduler.
// slave = scheduler side, master = producer/core/consumer side.
interface fib_job_scheduler_if
   import fib_pkg::*;
#(
   parameter int unsigned DATA_W = FIB_DATA_W
);
   logic              req_valid;
   logic [DATA_W-1:0] req_n;
   logic              req_ready;
   logic              fib_start;
   logic [DATA_W-1:0] fib_din;
   logic [DATA_W-1:0] fib_dout;
   logic              fib_done;
   logic              res_valid;
   logic [DATA_W-1:0] res_n;
   logic [DATA_W-1:0] res_f;
   logic              res_err;
   logic              res_ready;
   logic              busy;

   modport slave (
      input  req_valid, req_n, fib_dout, fib_done, res_ready,
      output req_ready, fib_start, fib_din, res_valid, res_n, res_f, res_err, busy
   );

   modport master (
      output req_valid, req_n, fib_dout, fib_done, res_ready,
      input  req_ready, fib_start, fib_din, res_valid, res_n, res_f, res_err, busy
   );
endinterface

// File: rtl/fib_req_fifo.sv
// Request FIFO (DATA_W x FIFO_DEPTH), first-word-fall-through read, async active-low reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fib_req_fifo
   import fib_pkg::*;
#(
   parameter int unsigned DATA_W     = FIB_DATA_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic              do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/fib_job_scheduler.sv
// Queues Fibonacci requests and runs them one at a time on the core, returning {n, F(n)}.
// Optional watchdog on the core wait: define FIB_SCHED_TIMEOUT_EN.
module fib_job_scheduler
   import fib_pkg::*;
#(
   parameter int unsigned DATA_W         = FIB_DATA_W,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                clk,
   input  logic                reset,
   fib_job_scheduler_if.slave  bus
);
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
      $error("fib_job_scheduler: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
   end

   sched_state_e      state_q, state_d;
   logic [DATA_W-1:0] n_q, f_q;
   logic              err_q;
   logic              first_q;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              done_seen, timeout;

   assign fifo_push = bus.req_valid && !fifo_full;

   fib_req_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (fifo_push),
      .wdata_i (bus.req_n),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // The first WAIT cycle may still see done from the previous job.
   assign done_seen = (state_q == WAIT) && !first_q && bus.fib_done;

`ifdef FIB_SCHED_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                wait_cnt_q <= '0;
      else if (state_q == ISSUE) wait_cnt_q <= '0;
      else if (state_q == WAIT)  wait_cnt_q <= wait_cnt_q + 1'b1;
   end

   assign timeout = (state_q == WAIT) && !done_seen && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         IDLE: if (!fifo_empty) begin
            state_d  = ISSUE;
            fifo_pop = 1'b1;
         end
         ISSUE: state_d = WAIT;
         WAIT:  if (done_seen || timeout) state_d = OUT;
         OUT: if (bus.res_ready) begin
            if (!fifo_empty) begin
               state_d  = ISSUE;
               fifo_pop = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_q     <= '0;
         f_q     <= '0;
         err_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         first_q <= (state_q == ISSUE);
         if (fifo_pop) n_q <= fifo_head;
         if (done_seen) begin
            f_q   <= bus.fib_dout;
            err_q <= 1'b0;
         end else if (timeout) begin
            f_q   <= '0;
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.req_ready = !fifo_full;
      bus.fib_start = (state_q == ISSUE);
      bus.fib_din   = n_q;
      bus.res_valid = (state_q == OUT);
      bus.res_n     = n_q;
      bus.res_f     = f_q;
      bus.res_err   = err_q;
      bus.busy      = (state_q != IDLE) || !fifo_empty;
   end
endmodule

// File: tb/tb_fib_job_scheduler.sv
// Scoreboard bench for fib_job_scheduler paired with a behavioural Fibonacci core.
// The timeout scenario runs only when FIB_SCHED_TIMEOUT_EN is defined.
module tb_fib_job_scheduler;
   import fib_pkg::*;

   localparam int unsigned DW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fib_job_scheduler_if #(.DATA_W(DW)) bus();

   fib_job_scheduler #(
      .DATA_W         (DW),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (256)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   // Core model: done stays high after a job and only falls one cycle after the next start.
   logic [DW-1:0] ca = '0, cb = '0, ccnt = '0, cdout = '0;
   logic          cdone = 1'b0;
   logic [1:0]    cph = 2'd0;
   logic          core_hold = 1'b0;

   always @(posedge clk) begin
      if (bus.fib_start) begin
         ca   <= '0;
         cb   <= 16'd1;
         ccnt <= bus.fib_din;
         cph  <= 2'd1;
      end else if (cph == 2'd1) begin
         cdone <= 1'b0;
         cph   <= 2'd2;
      end else if (cph == 2'd2) begin
         if (ccnt == '0) begin
            cdout <= ca;
            cdone <= 1'b1;
            cph   <= 2'd0;
         end else begin
            ca   <= cb;
            cb   <= ca + cb;
            ccnt <= ccnt - 1'b1;
         end
      end
   end

   assign bus.fib_done = cdone & ~core_hold;
   assign bus.fib_dout = cdout;

   int unsigned   n_pass  = 0;
   int unsigned   n_total = 0;
   fib_result_t   exp_q[$];
   logic [DW-1:0] start_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   initial begin : monitor
      fib_result_t cur, held;
      bit holding, prev_start;
      holding    = 1'b0;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            holding    = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (bus.fib_start) begin
               check("start_single_cycle", 64'(prev_start), 64'd0);
               if (start_q.size() == 0) check("start_expected", 64'd0, 64'd1);
               else check("start_din", 64'(bus.fib_din), 64'(start_q.pop_front()));
            end
            prev_start = bus.fib_start;
            if (bus.res_valid) begin
               cur = '{n: bus.res_n, f: bus.res_f, err: bus.res_err};
               if (holding) check("hold_stable", 64'(cur), 64'(held));
               if (bus.res_ready) begin
                  if (exp_q.size() == 0) check("result_expected", 64'd0, 64'd1);
                  else check("result", 64'(cur), 64'(exp_q.pop_front()));
                  holding = 1'b0;
               end else begin
                  holding = 1'b1;
                  held    = cur;
               end
            end else if (holding) begin
               check("valid_held", 64'd0, 64'd1);
               holding = 1'b0;
            end
         end
      end
   end

   task automatic push(input logic [DW-1:0] n, input logic [DW-1:0] f, input logic err,
                       input bit track, output bit stalled);
      int unsigned t = 0;
      stalled       = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_n     = n;
      while (!bus.req_ready && t < 300) begin
         stalled = 1'b1;
         @(posedge clk); #1;
         t++;
      end
      if (!bus.req_ready) begin
         check("push_accept", 64'd0, 64'd1);
         bus.req_valid = 1'b0;
         return;
      end
      if (track) exp_q.push_back('{n: n, f: f, err: err});
      start_q.push_back(n);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int unsigned t = 0;
      while ((exp_q.size() != 0 || bus.busy) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
      check({tag, "_fib_start"}, 64'(bus.fib_start), 64'd0);
      check({tag, "_busy"},      64'(bus.busy),      64'd0);
      check({tag, "_payload"},   64'({bus.res_n, bus.res_f, bus.res_err, bus.fib_din}), 64'd0);
   endtask

   initial begin : stimulus
      bit          st;
      int unsigned stalls;
      int unsigned t;
      bus.req_valid = 1'b0;
      bus.req_n     = '0;
      bus.res_ready = 1'b1;

      #2 rst_n = 1'b0;
      #1 reset_checks("rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single job, start latency
      push(16'd10, 16'd55, 1'b0, 1'b1, st);
      check("t1_no_start_yet", 64'(bus.fib_start), 64'd0);
      @(posedge clk); #1;
      check("t1_start", 64'(bus.fib_start), 64'd1);
      check("t1_din", 64'(bus.fib_din), 64'd10);
      @(posedge clk); #1;
      check("t1_start_drop", 64'(bus.fib_start), 64'd0);
      wait_drain("t1_drain");

      // back-to-back requests
      stalls = 0;
      push(16'd0,  16'd0,     1'b0, 1'b1, st); stalls += st;
      push(16'd1,  16'd1,     1'b0, 1'b1, st); stalls += st;
      push(16'd2,  16'd1,     1'b0, 1'b1, st); stalls += st;
      push(16'd24, 16'd46368, 1'b0, 1'b1, st); stalls += st;
      check("t2_req_ready_held", 64'(stalls), 64'd0);
      wait_drain("t2_drain");

      // backpressure fills the FIFO
      bus.res_ready = 1'b0;
      push(16'd3, 16'd2, 1'b0, 1'b1, st);
      push(16'd4, 16'd3, 1'b0, 1'b1, st);
      push(16'd5, 16'd5, 1'b0, 1'b1, st);
      push(16'd6, 16'd8, 1'b0, 1'b1, st);
      push(16'd8, 16'd21, 1'b0, 1'b1, st);
      repeat (20) @(posedge clk);
      #1;
      check("t3_full", 64'(bus.req_ready), 64'd0);
      check("t3_valid", 64'(bus.res_valid), 64'd1);
      check("t3_head_n", 64'(bus.res_n), 64'd3);
      fork
         push(16'd9, 16'd34, 1'b0, 1'b1, st);
         begin
            repeat (5) @(posedge clk);
            #1 bus.res_ready = 1'b1;
         end
      join
      check("t3_sixth_stalled", 64'(st), 64'd1);
      wait_drain("t3_drain");

      // stale done from the previous job
      check("t4_stale_done", 64'(bus.fib_done), 64'd1);
      push(16'd7, 16'd13, 1'b0, 1'b1, st);
      wait_drain("t4_drain");

      // reset mid-job
      push(16'd20, 16'd6765, 1'b0, 1'b0, st);
      t = 0;
      while (!bus.fib_start && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check("t5_started", 64'(bus.fib_start), 64'd1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 reset_checks("t5");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push(16'd5, 16'd5, 1'b0, 1'b1, st);
      wait_drain("t5_drain");

`ifdef FIB_SCHED_TIMEOUT_EN
      core_hold = 1'b1;
      push(16'd11, 16'd0,   1'b1, 1'b1, st);
      push(16'd12, 16'd144, 1'b0, 1'b1, st);
      t = 0;
      while (!bus.res_valid && t < 600) begin
         @(posedge clk); #1;
         t++;
      end
      check("t6_timeout_seen", 64'(bus.res_valid), 64'd1);
      core_hold = 1'b0;
      wait_drain("t6_drain");
`endif

      check("starts_consumed", 64'(start_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
